// File: rtl/switch_bank_ctrl_pkg.sv
// Shared I/O definitions for the switch input region: default read-data width,
// status-word offset and the read-address decode used by the CPU read path.
package switch_bank_ctrl_pkg;

  localparam int unsigned DATA_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    RD_BANK   = 2'd0,
    RD_STATUS = 2'd1,
    RD_RSVD   = 2'd2
  } rd_sel_e;

  // Status word sits directly after the last bank.
  function automatic int unsigned status_offset(input int unsigned n_banks);
    return n_banks;
  endfunction

  function automatic rd_sel_e decode_addr(input int unsigned addr, input int unsigned n_banks);
    if (addr < n_banks)                     return RD_BANK;
    if (addr == status_offset(n_banks))     return RD_STATUS;
    return RD_RSVD;
  endfunction

endpackage

// File: rtl/switch_bank_ctrl_debounce.sv
// One switch bank: 2-flop synchroniser followed by a hold-time debounce filter.
// chg_pulse_o is high in the cycle whose rising edge commits a new stable value.
module switch_debounce #(
  parameter int unsigned BANK_W   = 8,
  parameter int unsigned DB_LIMIT = 1000000,
  parameter int unsigned DB_CNT_W = 20
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [BANK_W-1:0] pins_i,
  output logic [BANK_W-1:0] stable_o,
  output logic              chg_pulse_o
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_LIMIT - 1);

  logic [BANK_W-1:0]   sync1_q, sync2_q, cand_q, stable_q;
  logic [DB_CNT_W-1:0] cnt_q;

  always_comb begin
    chg_pulse_o = (sync2_q == cand_q) && (cand_q != stable_q) && (cnt_q == CNT_LAST);
    stable_o    = stable_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= pins_i;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        cnt_q  <= '0;
      end else if (cand_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= cand_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + DB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/switch_bank_ctrl.sv
// Debounced multi-bank switch port with sticky change flags, a read-to-clear
// status word, registered MMIO read data and a change interrupt.
module switch_bank_ctrl
  import switch_bank_ctrl_pkg::*;
#(
  parameter int unsigned BANK_W   = 8,
  parameter int unsigned N_BANKS  = 3,
  parameter int unsigned DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned DB_LIMIT = 1000000,
  parameter int unsigned DB_CNT_W = 20
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [N_BANKS*BANK_W-1:0] switches,
  input  logic                      switch_ctrl,
  input  logic                      io_read,
  input  logic [ADDR_W-1:0]         switch_addr,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic [N_BANKS-1:0]        chg_flags,
  output logic                      irq
);

  if (BANK_W > DATA_W) begin : g_chk_bank_w
    $error("switch_bank_ctrl: BANK_W must not exceed DATA_W");
  end
  if (N_BANKS > DATA_W) begin : g_chk_status_w
    $error("switch_bank_ctrl: N_BANKS must not exceed DATA_W");
  end
  if ((64'(1) << ADDR_W) < 64'(N_BANKS + 1)) begin : g_chk_addr_w
    $error("switch_bank_ctrl: ADDR_W too narrow for banks plus status");
  end
  if (DB_LIMIT < 1 || (64'(1) << DB_CNT_W) <= 64'(DB_LIMIT)) begin : g_chk_db
    $error("switch_bank_ctrl: DB_LIMIT must be >= 1 and fit in DB_CNT_W");
  end

  logic [BANK_W-1:0]  stable_w [N_BANKS];
  logic [N_BANKS-1:0] chg_pulse;

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    switch_debounce #(
      .BANK_W  (BANK_W),
      .DB_LIMIT(DB_LIMIT),
      .DB_CNT_W(DB_CNT_W)
    ) u_db (
      .clock      (clock),
      .reset_n    (reset_n),
      .pins_i     (switches[b*BANK_W +: BANK_W]),
      .stable_o   (stable_w[b]),
      .chg_pulse_o(chg_pulse[b])
    );
  end

  logic               rd_req, status_rd;
  rd_sel_e            rd_sel;
  logic [BANK_W-1:0]  bank_rd;
  logic [DATA_W-1:0]  rd_data_d, rd_data_q;
  logic               rd_valid_q;
  logic [N_BANKS-1:0] chg_flags_d, chg_flags_q;
  logic               irq_q;

  always_comb begin
    rd_req    = switch_ctrl & io_read;
    rd_sel    = decode_addr(32'(switch_addr), N_BANKS);
    status_rd = rd_req && (rd_sel == RD_STATUS);

    bank_rd = '0;
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      if (32'(switch_addr) == b) bank_rd = stable_w[b];
    end

    rd_data_d = rd_data_q;
    if (rd_req) begin
      unique case (rd_sel)
        RD_BANK:   rd_data_d = DATA_W'(bank_rd);
        RD_STATUS: rd_data_d = DATA_W'(chg_flags_q);
        default:   rd_data_d = '0;
      endcase
    end

    // A pulse on the same edge as a status read survives the clear.
    chg_flags_d = chg_pulse | (chg_flags_q & ~{N_BANKS{status_rd}});
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      chg_flags_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_req;
      chg_flags_q <= chg_flags_d;
      irq_q       <= |chg_flags_q;
    end
  end

  always_comb begin
    rd_data   = rd_data_q;
    rd_valid  = rd_valid_q;
    chg_flags = chg_flags_q;
    irq       = irq_q;
  end

endmodule
